// File: rtl/io_port_bank.sv
// Memory-mapped parallel I/O bank: per-port DATA/DDR/IFR/IER registers,
// synchronised pin readback and rising-edge interrupt flags.
module io_port_bank #(
  parameter int                N_PORTS     = 2,
  parameter int                WIDTH       = 8,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'hFFC0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read_write,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     selected,
  input  logic [N_PORTS*WIDTH-1:0] port_in,
  output logic [N_PORTS*WIDTH-1:0] port_out,
  output logic [N_PORTS*WIDTH-1:0] port_dir,
  output logic                     irq
);

  localparam int NW = N_PORTS * WIDTH;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0]   ARM_MAX = AW'(SYNC_STAGES + 1);
  localparam logic [ADDR_W:0] LO      = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI      = LO + (ADDR_W + 1)'(4 * N_PORTS);

  logic [ADDR_W-1:0] offset;
  logic [PW-1:0]     port_idx;
  logic [1:0]        reg_sel;
  logic              wr_en;
  logic              rd_en;

  assign selected = ({1'b0, address} >= LO) && ({1'b0, address} < HI);
  assign offset   = address - BASE_ADDR;
  assign port_idx = PW'(offset >> 2);
  assign reg_sel  = offset[1:0];
  assign wr_en    = selected & read_write;
  assign rd_en    = selected & ~read_write;

  logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
  logic [NW-1:0]                  sync_in;
  logic [NW-1:0]                  prev_q;
  logic [AW-1:0]                  arm_q;
  logic [AW-1:0]                  arm_d;
  logic                           armed;

  assign sync_in = sync_q[SYNC_STAGES-1];
  // Flags stay masked until the chain and edge history hold real samples.
  assign armed   = (arm_q == ARM_MAX);
  assign arm_d   = armed ? arm_q : arm_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], port_in};
      prev_q <= sync_in;
      arm_q  <= arm_d;
    end
  end

  logic [WIDTH-1:0]   rd_val [N_PORTS];
  logic [N_PORTS-1:0] irq_vec;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] ddr_q, ddr_d;
    logic [WIDTH-1:0] ifr_q, ifr_d;
    logic [WIDTH-1:0] ier_q, ier_d;
    logic [WIDTH-1:0] pin_s, pin_p, rise, clr;
    logic             hit;

    assign hit   = (port_idx == PW'(p));
    assign pin_s = sync_in[p*WIDTH +: WIDTH];
    assign pin_p = prev_q[p*WIDTH +: WIDTH];
    assign rise  = pin_s & ~pin_p & ~ddr_q & {WIDTH{armed}};
    assign clr   = (wr_en && hit && reg_sel == 2'd2) ? data_in : '0;

    always_comb begin
      data_d = data_q;
      ddr_d  = ddr_q;
      ier_d  = ier_q;
      // A new edge wins over a write-1-to-clear of the same bit.
      ifr_d  = (ifr_q & ~clr) | rise;
      if (wr_en && hit) begin
        case (reg_sel)
          2'd0:    data_d = data_in;
          2'd1:    ddr_d  = data_in;
          2'd3:    ier_d  = data_in;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        ddr_q  <= '0;
        ifr_q  <= '0;
        ier_q  <= '0;
      end else begin
        data_q <= data_d;
        ddr_q  <= ddr_d;
        ifr_q  <= ifr_d;
        ier_q  <= ier_d;
      end
    end

    assign rd_val[p] = (reg_sel == 2'd0) ? ((data_q & ddr_q) | (pin_s & ~ddr_q)) :
                       (reg_sel == 2'd1) ? ddr_q :
                       (reg_sel == 2'd2) ? ifr_q : ier_q;

    assign port_out[p*WIDTH +: WIDTH] = data_q;
    assign port_dir[p*WIDTH +: WIDTH] = ddr_q;
    assign irq_vec[p]                 = |(ifr_q & ier_q);
  end

  assign irq = |irq_vec;

  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (port_idx == PW'(p)) dout_d = rd_val[p];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Randomised and directed bench for io_port_bank against a pin-sample-history
// reference model of the register bank.
module tb_io_port_bank;

  localparam int          N    = 2;
  localparam int          W    = 8;
  localparam int          S    = 2;
  localparam logic [15:0] BASE = 16'hFFC0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic        read_write = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        selected;
  logic [15:0] port_in = '0;
  logic [15:0] port_out;
  logic [15:0] port_dir;
  logic        irq;

  always #5 clk = ~clk;

  io_port_bank #(
    .N_PORTS(N), .WIDTH(W), .ADDR_W(16), .BASE_ADDR(BASE), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read_write(read_write),
    .data_in(data_in), .data_out(data_out), .selected(selected),
    .port_in(port_in), .port_out(port_out), .port_dir(port_dir), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: registers as arrays, pins as a history of clock samples.
  logic [7:0]  m_data [N];
  logic [7:0]  m_ddr  [N];
  logic [7:0]  m_ifr  [N];
  logic [7:0]  m_ier  [N];
  logic [7:0]  m_dout;
  logic [15:0] hist [$];

  function automatic logic [15:0] hsample(int k);
    return (hist.size() > k) ? hist[k] : 16'h0000;
  endfunction

  function automatic logic m_sel(logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 4 * N);
  endfunction

  function automatic logic [15:0] m_pout();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_data[i];
    return v;
  endfunction

  function automatic logic [15:0] m_pdir();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_ddr[i];
    return v;
  endfunction

  function automatic logic m_irq();
    logic v = 1'b0;
    for (int i = 0; i < N; i++) v |= |(m_ifr[i] & m_ier[i]);
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin : mdl
    logic [15:0] sin, pv, rise;
    logic [7:0]  nifr [N];
    int          off, p, r;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_data[i] = '0; m_ddr[i] = '0; m_ifr[i] = '0; m_ier[i] = '0;
      end
      m_dout = '0;
      hist.delete();
    end else begin
      // A pin edge counts once two genuine post-reset samples have passed the chain.
      sin  = hsample(S - 1);
      pv   = hsample(S);
      rise = (hist.size() >= S + 1) ? (sin & ~pv) : 16'h0000;
      for (int i = 0; i < N; i++) nifr[i] = m_ifr[i] | (rise[i*8 +: 8] & ~m_ddr[i]);
      if (m_sel(address)) begin
        off = int'(address) - int'(BASE);
        p   = off / 4;
        r   = off % 4;
        if (!read_write) begin
          case (r)
            0: m_dout = (m_data[p] & m_ddr[p]) | (sin[p*8 +: 8] & ~m_ddr[p]);
            1: m_dout = m_ddr[p];
            2: m_dout = m_ifr[p];
            default: m_dout = m_ier[p];
          endcase
        end else begin
          case (r)
            0: m_data[p] = data_in;
            1: m_ddr[p]  = data_in;
            2: nifr[p]   = (m_ifr[p] & ~data_in) | (rise[p*8 +: 8] & ~m_ddr[p]);
            default: m_ier[p] = data_in;
          endcase
        end
      end
      for (int i = 0; i < N; i++) m_ifr[i] = nifr[i];
      hist.push_front(port_in);
      if (hist.size() > S + 2) void'(hist.pop_back());
    end
  end

  task automatic compare_all();
    check("port_out", port_out, m_pout());
    check("port_dir", port_dir, m_pdir());
    check("data_out", data_out, m_dout);
    check("irq", irq, m_irq());
    check("selected", selected, m_sel(address));
  endtask

  task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
    address = a; read_write = rw; data_in = d;
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b1, d);
  endtask

  task automatic rd(input logic [15:0] a);
    bus(a, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(16'h0100, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_port_out", port_out, 16'h0000);
    check("rst_port_dir", port_dir, 16'h0000);
    check("rst_irq", irq, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    reset = 1'b0;

    port_in = 16'h00A5;
    rd(BASE + 16'd1);
    check("ddr0_read", data_out, 8'h00);
    idle(S);
    rd(BASE);
    check("data0_input_read", data_out, 8'hA5);
    check("dir_after_reset", port_dir, 16'h0000);
    check("irq_after_reset", irq, 1'b0);

    wr(BASE + 16'd1, 8'hF0);
    wr(BASE, 8'h3C);
    port_in[7:0] = 8'h0F;
    idle(S + 1);
    check("port_out_lo", port_out[7:0], 8'h3C);
    check("port_dir_lo", port_dir[7:0], 8'hF0);
    rd(BASE);
    check("data0_mixed_read", data_out, 8'h3F);

    wr(BASE + 16'd7, 8'h01);
    port_in[8] = 1'b1;
    for (int i = 0; i < S + 2 && !irq; i++) idle(1);
    check("irq_on_edge", irq, 1'b1);
    rd(BASE + 16'd6);
    check("ifr1_read", data_out, 8'h01);
    wr(BASE + 16'd6, 8'h01);
    check("irq_after_w1c", irq, 1'b0);

    port_in[8] = 1'b0;
    idle(S + 2);
    port_in[8] = 1'b1;
    idle(S);
    wr(BASE + 16'd6, 8'h01);
    rd(BASE + 16'd6);
    check("set_beats_clear", data_out[0], 1'b1);
    check("irq_set_beats_clear", irq, 1'b1);
    wr(BASE + 16'd6, 8'hFF);

    port_in = 16'hFFFF;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr(BASE + 16'd3, 8'hFF);
    wr(BASE + 16'd7, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check("irq_high_at_release", irq, 1'b0);
    end
    rd(BASE + 16'd2);
    check("ifr0_high_at_release", data_out, 8'h00);
    rd(BASE + 16'd6);
    check("ifr1_high_at_release", data_out, 8'h00);

    rd(BASE + 16'd4);
    check("data1_pins_high", data_out, 8'hFF);
    held = data_out;
    wr(BASE + 16'd8, 8'h55);
    check("sel_above", selected, 1'b0);
    check("hold_above", data_out, held);
    wr(16'hFFBF, 8'h55);
    check("sel_below", selected, 1'b0);
    check("hold_below", data_out, held);
    rd(BASE + 16'd8);
    check("hold_rd_above", data_out, held);
    check("oor_port_out", port_out, 16'h0000);
    check("oor_port_dir", port_dir, 16'h0000);

    wr(BASE + 16'd1, 8'hFF);
    wr(BASE, 8'hAA);
    check("pre_reset_out", port_out[7:0], 8'hAA);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", port_out, 16'h0000);
    check("async_rst_dir", port_dir, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int it = 0; it < 600; it++) begin
      logic [15:0] a;
      int sel;
      if ($urandom_range(0, 3) == 0) port_in = port_in ^ (16'($urandom) & 16'($urandom));
      sel = $urandom_range(0, 19);
      if (sel < 14)      a = BASE + 16'($urandom_range(0, 7));
      else if (sel < 17) a = BASE + 16'($urandom_range(8, 15));
      else               a = 16'($urandom);
      if (it == 300) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      bus(a, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Memory-mapped parallel I/O block on the 6502 bus; generalises the fixed write-only output latches at 16'hFFFF/16'hFFFE.
- Provides N_PORTS bidirectional ports of WIDTH bits, each with a data-direction register, synchronised input readback, edge-triggered interrupt flags and an interrupt enable mask.
- Sits beside ram on address_out/cpu_data_out; the top level muxes data_out into cpu_data_in when selected is high. It drives the LCD and hex displays through port_out.

Parameters:
N_PORTS, 2, number of ports (1..16)
WIDTH, 8, bits per port
ADDR_W, 16, bus address width
BASE_ADDR, 16'hFFC0, first register address; must be aligned to 4*N_PORTS rounded up to a power of two
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  CPU address
read_write  in  1  1 = write cycle, 0 = read cycle
data_in  in  WIDTH  CPU write data
data_out  out  WIDTH  registered read data
selected  out  1  combinational: address lies in BASE_ADDR .. BASE_ADDR+4*N_PORTS-1
port_in  in  N_PORTS*WIDTH  external pin inputs; port i occupies bits [i*WIDTH +: WIDTH]
port_out  out  N_PORTS*WIDTH  output latches
port_dir  out  N_PORTS*WIDTH  direction per bit: 1 = output, 0 = input
irq  out  1  OR over all ports of (IFR & IER)

Behaviour:
- Address decode:
  - offset = address - BASE_ADDR; port = offset[.. :2]; reg = offset[1:0].
  - reg 0 = DATA, 1 = DDR, 2 = IFR, 3 = IER.
- Reset (asynchronous): port_out, port_dir, IFR, IER, data_out, synchroniser stages, edge history and arm counter all go to 0. irq=0. All pins are inputs.
- Write: on posedge with read_write=1 and selected=1, the addressed register updates. The new value is visible on port_out/port_dir on the following cycle.
  - DATA write loads the output latch for every bit, including input bits; the value takes effect when the direction changes.
  - IFR write is write-1-to-clear.
- Read: on posedge with read_write=0 and selected=1, data_out is loaded from the addressed register. One cycle latency, matching ram.
  - DATA read returns (port_out & DDR) | (sync_in & ~DDR).
  - data_out holds its value on writes and on unselected cycles.
- Input path: each port_in bit passes through a SYNC_STAGES flop chain. sync_in is the last stage; prev holds sync_in delayed by one cycle.
- Edge flags:
  - IFR bit sets when sync_in=1, prev=0 and DDR=0 for that bit.
  - Set has priority over a simultaneous write-1-to-clear of the same bit.
  - Bits with DDR=1 never set; existing flags on those bits persist until cleared.
- Arm counter: counts 0..SYNC_STAGES+1 after reset. Edge flags are suppressed until it saturates, so pins already high at reset release raise no flag.
- Out-of-range addresses: no register changes; data_out holds.
- Reset mid-operation clears every register immediately, regardless of clk.
- irq is combinational from registers only, with no path from address or data inputs.

Test Plan:
- Reset, then read BASE+1, BASE+0 with port_in=16'h00A5 → data_out 8'h00 then 8'hA5 (after SYNC_STAGES+1 cycles); port_dir=0, irq=0.
- Write DDR0=8'hF0, DATA0=8'h3C, port_in[7:0]=8'h0F → port_out[7:0]=8'h3C, port_dir[7:0]=8'hF0; read DATA0 → 8'h3F.
- Write IER1=8'h01, drive port_in[8] 0→1 → IFR1 reads 8'h01 and irq=1 within SYNC_STAGES+1 cycles; write IFR1=8'h01 → irq=0 next cycle.
- Rising edge on port_in[8] in the same cycle as a write IFR1=8'h01 → IFR1 bit0 stays 1.
- Hold port_in=all ones through reset release → no IFR bits set, irq=0 for 20 cycles.
- Write to BASE+4*N_PORTS and to BASE-1 → no register changes, selected=0, data_out unchanged.
